mode_sequencer: RTL

Parametrised mode controller for the digital clock: it turns a raw "mode" push-button into a debounced, clock-synchronous mode index. The index is consumed by the display mux and the time/alarm setting logic. It sits between the board button/switch inputs and the clock core. It also provides:
- per-mode enable masking,
- a long-press return to normal mode,
- an inactivity timeout back to normal mode.

---
 rtl/reloj_pkg.sv | 12 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/mode_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reloj_pkg.sv
// Shared constants for the digital clock: mode indices and
// the default number of user-selectable modes.
package reloj_pkg;

    localparam int NUM_MODES_DEFAULT = 4;

    localparam int MODE_NORMAL     = 0;
    localparam int MODE_SET_TIME   = 1;
    localparam int MODE_SET_ALARM  = 2;
    localparam int MODE_ALARM_VIEW = 3;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter
// and rising-edge detector on the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic stable_o,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q;
    logic          stable_d_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            stable_q   <= 1'b0;
            stable_d_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= btn_i;
            s2_q       <= s1_q;
            stable_d_q <= stable_q;
            // Any sample that agrees with the accepted level restarts the run
            if (s2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= s2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable_o = stable_q;
    assign press_o  = stable_q & ~stable_d_q;

endmodule

// File: rtl/mode_sequencer.sv
// Mode controller: debounced button steps through enabled modes,
// with long-press, inactivity timeout and disable returning to mode 0.
module mode_sequencer
    import reloj_pkg::*;
#(
    parameter int NUM_MODES       = NUM_MODES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONGPRESS_TICKS = 2,
    parameter int TIMEOUT_TICKS   = 30,
    localparam int MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_1hz,
    input  logic                 btn_mode,
    input  logic [NUM_MODES-1:0] mode_en,
    output logic [MODE_W-1:0]    mode,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic                 mode_changed,
    output logic                 in_setup
);

    localparam int LPW = (LONGPRESS_TICKS > 0) ? $clog2(LONGPRESS_TICKS + 1) : 1;
    localparam int TOW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [LPW-1:0] LP_MAX  = LPW'(LONGPRESS_TICKS);
    localparam logic [LPW-1:0] LP_LAST =
        LPW'((LONGPRESS_TICKS > 0) ? LONGPRESS_TICKS - 1 : 0);
    localparam logic [TOW-1:0] TO_MAX  = TOW'(TIMEOUT_TICKS);
    localparam logic [TOW-1:0] TO_LAST =
        TOW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
    localparam logic [MODE_W-1:0] M_NORMAL = MODE_W'(MODE_NORMAL);

    logic                 stable;
    logic                 press;
    logic [NUM_MODES-1:0] en_eff;
    logic [MODE_W-1:0]    nxt_mode;
    logic [MODE_W-1:0]    mode_d;
    logic [MODE_W-1:0]    mode_q;
    logic [NUM_MODES-1:0] onehot_q;
    logic                 changed_q;
    logic                 setup_q;
    logic [LPW-1:0]       lp_d;
    logic [LPW-1:0]       lp_q;
    logic [TOW-1:0]       to_d;
    logic [TOW-1:0]       to_q;
    logic                 drop;
    logic                 force_lp;
    logic                 force_to;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn_mode),
        .stable_o(stable),
        .press_o (press)
    );

    assign en_eff = mode_en | NUM_MODES'(1);

    // Lowest enabled index above the current one; otherwise wrap to 0
    always_comb begin
        nxt_mode = M_NORMAL;
        for (int i = NUM_MODES - 1; i >= 1; i--) begin
            if (en_eff[i] && (MODE_W'(i) > mode_q)) begin
                nxt_mode = MODE_W'(i);
            end
        end
    end

    always_comb begin
        drop     = (mode_q != M_NORMAL) && !en_eff[mode_q];
        force_lp = (LONGPRESS_TICKS > 0) && stable && tick_1hz
                   && (lp_q == LP_LAST);
        force_to = (TIMEOUT_TICKS > 0) && (mode_q != M_NORMAL)
                   && tick_1hz && !press && (to_q == TO_LAST);

        mode_d = mode_q;
        if (drop || force_lp || force_to) begin
            mode_d = M_NORMAL;
        end else if (press) begin
            mode_d = nxt_mode;
        end

        lp_d = lp_q;
        if (!stable) begin
            lp_d = '0;
        end else if (tick_1hz && (lp_q != LP_MAX)) begin
            lp_d = lp_q + 1'b1;
        end

        to_d = to_q;
        if ((mode_q == M_NORMAL) || press || (mode_d != mode_q)) begin
            to_d = '0;
        end else if (tick_1hz && (to_q != TO_MAX)) begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= M_NORMAL;
            onehot_q  <= NUM_MODES'(1);
            changed_q <= 1'b0;
            setup_q   <= 1'b0;
            lp_q      <= '0;
            to_q      <= '0;
        end else begin
            mode_q    <= mode_d;
            onehot_q  <= NUM_MODES'(1) << mode_d;
            changed_q <= (mode_d != mode_q);
            setup_q   <= (mode_d != M_NORMAL);
            lp_q      <= lp_d;
            to_q      <= to_d;
        end
    end

    assign mode         = mode_q;
    assign mode_onehot  = onehot_q;
    assign mode_changed = changed_q;
    assign in_setup     = setup_q;

endmodule
